cic_ctrl: RTL and testbench
===========================

CIC_CTRL -- requirements
Module: cic_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH_O, default 16, CIC output sample width.
REQ-002 SHALL have parameter RST_CYCLES, default 4, minimum number of clk cycles that cic_rst_n is held low after start.
REQ-003 SHALL have parameter SETTLE_OUTPUTS, default 5, number of decimated outputs discarded after each restart.
REQ-004 SHALL have port clk, input, 1 bit: rising-edge clock shared with the CIC decimator.
REQ-005 SHALL have port arst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have ports start and stop, inputs, 1 bit each: single-cycle command pulses.
REQ-007 SHALL have port in_valid, input, 1 bit: ADC sample strobe.
REQ-008 SHALL have port cic_rst_n, output, 1 bit: registered reset to the CIC's arst_n.
REQ-009 SHALL have port cic_en, output, 1 bit: enable to the CIC.
REQ-010 SHALL have ports cic_data_clk, input, 1 bit, and cic_data_out, input, DATA_WIDTH_O bits, signed: the CIC's decimated strobe and sample.
REQ-011 SHALL have ports m_data, output, DATA_WIDTH_O bits; m_valid, output, 1 bit; m_ready, input, 1 bit: downstream valid/ready stream.
REQ-012 SHALL have port running, output, 1 bit: high in state RUN.
REQ-013 SHALL have port overrun, output, 1 bit: sticky sample-drop flag.

Function
REQ-014 SHALL implement FSM states IDLE, RESET, SETTLE and RUN.
REQ-015 IDLE SHALL hold cic_rst_n=0 and cic_en=0, and SHALL move to RESET on start.
REQ-016 RESET SHALL keep cic_rst_n=0 for exactly RST_CYCLES cycles, then enter SETTLE with cic_rst_n=1 registered on that same edge.
REQ-017 cic_en SHALL equal in_valid AND (state is SETTLE or RUN), combinationally, so that it is cycle-aligned with the ADC data.
REQ-018 SETTLE SHALL count cic_data_clk pulses and discard each one; on the SETTLE_OUTPUTS-th pulse it SHALL enter RUN on the next edge.
REQ-019 In RUN, each cic_data_clk pulse SHALL schedule a capture of cic_data_out in the following cycle, because the CIC output register updates one cycle after the strobe.
REQ-020 At a capture cycle, if m_valid=0 or (m_valid AND m_ready), the block SHALL load m_data and set m_valid=1 on that edge.
REQ-021 At a capture cycle, if instead m_valid AND NOT m_ready, the block SHALL drop the new sample, keep m_data unchanged, and set overrun=1.
REQ-022 m_valid SHALL clear on an m_ready handshake that has no coincident capture; m_data SHALL stay stable while m_valid AND NOT m_ready.
REQ-023 stop in RESET, SETTLE or RUN SHALL force IDLE on the next edge: cic_rst_n=0, cic_en=0, pending capture discarded, settle counter cleared.
REQ-024 stop SHALL leave a held m_valid/m_data in place until it is accepted.
REQ-025 start outside IDLE SHALL be ignored; start and stop in the same cycle SHALL resolve as stop.
REQ-026 overrun SHALL clear only on reset or on an accepted start.
REQ-027 running SHALL be registered state decode, high only in RUN.

Reset
REQ-028 arst_n low SHALL asynchronously force state=IDLE, cic_rst_n=0, m_valid=0, m_data=0, overrun=0, running=0, and all counters to 0.
REQ-029 Deassertion of arst_n SHALL leave the block in IDLE; the CIC SHALL stay in reset until start.

Configuration
REQ-030 With macro CIC_CTRL_OVR_CNT_EN defined, the block SHALL add output port ovr_cnt[15:0]: a count of dropped samples, saturating at 16'hFFFF, cleared with overrun.
REQ-031 Without CIC_CTRL_OVR_CNT_EN, port ovr_cnt and its counter SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-032 Shared package cic_pkg SHALL hold the FSM state enum typedef, the default DATA_WIDTH_O, and the counter width constants.
REQ-033 The one-entry valid/ready output register SHALL be a sub-module named cic_ctrl_oreg; the FSM and counters SHALL stay in cic_ctrl.

Verification
REQ-034 Reset then start: cic_rst_n low for 4 cycles after start then high; cic_en=0 before SETTLE; first 5 cic_data_clk pulses produce no m_valid; the 6th pulse yields m_valid one cycle later with m_data equal to cic_data_out in that cycle.
REQ-035 m_ready held 1 in RUN with strobes 8 cycles apart: each sample 16'sh1234, 16'sh8001, ... appears on m_data once, in order, with overrun=0.
REQ-036 m_ready held 0 across 3 strobes: m_data keeps the first sample, overrun=1, ovr_cnt=2 (macro on); release m_ready -> m_valid drops after one handshake.
REQ-037 stop during SETTLE at pulse 3: next cycle is IDLE with cic_rst_n=0; a later start repeats the full RESET plus 5-output settle.
REQ-038 start and stop in the same cycle from RUN -> IDLE; start in SETTLE -> ignored, counters continue.
REQ-039 arst_n asserted mid-RUN with m_valid=1 -> all outputs return to reset values immediately (asynchronously).

Source files
------------

// File: rtl/cic_pkg.sv
// Shared types and constants for the CIC decimator control slice.
package cic_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RESET,
      ST_SETTLE,
      ST_RUN
   } cic_state_t;

   localparam int unsigned DATA_WIDTH_O_DEF = 16;
   localparam int unsigned CNT_W            = 8;
   localparam int unsigned OVR_CNT_W        = 16;

endpackage

// File: rtl/cic_ctrl_oreg.sv
// One-entry valid/ready holding register for decimated CIC samples.
module cic_ctrl_oreg #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         arst_n,
   input  logic         load,
   input  logic [W-1:0] din,
   input  logic         m_ready,
   output logic [W-1:0] m_data,
   output logic         m_valid,
   output logic         drop
);

   logic accept;

   // A capture is accepted when the slot is empty or is being drained this cycle.
   assign accept = load && (!m_valid || m_ready);
   assign drop   = load && m_valid && !m_ready;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         m_data  <= '0;
         m_valid <= 1'b0;
      end else if (accept) begin
         m_data  <= din;
         m_valid <= 1'b1;
      end else if (m_ready) begin
         m_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/cic_ctrl.sv
// Start/stop sequencing, settle discard and output capture for a CIC decimator.
// Optional dropped-sample counter port ovr_cnt is enabled by CIC_CTRL_OVR_CNT_EN.
module cic_ctrl
   import cic_pkg::*;
#(
   parameter int unsigned DATA_WIDTH_O   = DATA_WIDTH_O_DEF,
   parameter int unsigned RST_CYCLES     = 4,
   parameter int unsigned SETTLE_OUTPUTS = 5
) (
   input  logic                           clk,
   input  logic                           arst_n,
   input  logic                           start,
   input  logic                           stop,
   input  logic                           in_valid,
   output logic                           cic_rst_n,
   output logic                           cic_en,
   input  logic                           cic_data_clk,
   input  logic signed [DATA_WIDTH_O-1:0] cic_data_out,
   output logic        [DATA_WIDTH_O-1:0] m_data,
   output logic                           m_valid,
   input  logic                           m_ready,
   output logic                           running,
   output logic                           overrun
`ifdef CIC_CTRL_OVR_CNT_EN
   ,
   output logic        [OVR_CNT_W-1:0]    ovr_cnt
`endif
);

   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_OUTPUTS - 1);

   cic_state_t       state_q, state_d;
   logic [CNT_W-1:0] rst_cnt_q, rst_cnt_d;
   logic [CNT_W-1:0] settle_cnt_q, settle_cnt_d;
   logic             cap_q, cap_d;
   logic             start_ok;
   logic             capture;
   logic             drop;

   assign cic_en  = in_valid && ((state_q == ST_SETTLE) || (state_q == ST_RUN));
   // A stop in the capture cycle discards the pending sample.
   assign capture = cap_q && !stop;

   always_comb begin
      state_d      = state_q;
      rst_cnt_d    = rst_cnt_q;
      settle_cnt_d = settle_cnt_q;
      cap_d        = 1'b0;
      start_ok     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start && !stop) begin
               state_d   = ST_RESET;
               rst_cnt_d = '0;
               start_ok  = 1'b1;
            end
         end
         ST_RESET: begin
            if (rst_cnt_q == RST_LAST) begin
               state_d   = ST_SETTLE;
               rst_cnt_d = '0;
            end else begin
               rst_cnt_d = rst_cnt_q + CNT_ONE;
            end
         end
         ST_SETTLE: begin
            if (cic_data_clk) begin
               if (settle_cnt_q == SETTLE_LAST) begin
                  state_d      = ST_RUN;
                  settle_cnt_d = '0;
               end else begin
                  settle_cnt_d = settle_cnt_q + CNT_ONE;
               end
            end
         end
         ST_RUN: begin
            cap_d = cic_data_clk;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (stop) begin
         state_d      = ST_IDLE;
         rst_cnt_d    = '0;
         settle_cnt_d = '0;
         cap_d        = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q      <= ST_IDLE;
         rst_cnt_q    <= '0;
         settle_cnt_q <= '0;
         cap_q        <= 1'b0;
         cic_rst_n    <= 1'b0;
         running      <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         state_q      <= state_d;
         rst_cnt_q    <= rst_cnt_d;
         settle_cnt_q <= settle_cnt_d;
         cap_q        <= cap_d;
         cic_rst_n    <= (state_d == ST_SETTLE) || (state_d == ST_RUN);
         running      <= (state_d == ST_RUN);
         if (start_ok) begin
            overrun <= 1'b0;
         end else if (drop) begin
            overrun <= 1'b1;
         end
      end
   end

`ifdef CIC_CTRL_OVR_CNT_EN
   localparam logic [OVR_CNT_W-1:0] OVR_ONE = OVR_CNT_W'(1);

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         ovr_cnt <= '0;
      end else if (start_ok) begin
         ovr_cnt <= '0;
      end else if (drop && (ovr_cnt != '1)) begin
         ovr_cnt <= ovr_cnt + OVR_ONE;
      end
   end
`endif

   cic_ctrl_oreg #(
      .W (DATA_WIDTH_O)
   ) u_oreg (
      .clk     (clk),
      .arst_n  (arst_n),
      .load    (capture),
      .din     (cic_data_out),
      .m_ready (m_ready),
      .m_data  (m_data),
      .m_valid (m_valid),
      .drop    (drop)
   );

endmodule

// File: tb/tb_cic_ctrl.sv
// Directed scoreboard bench for cic_ctrl; checks ovr_cnt when CIC_CTRL_OVR_CNT_EN is defined.
module tb_cic_ctrl;

   logic        clk = 1'b0;
   logic        arst_n;
   logic        start, stop, in_valid;
   logic        cic_rst_n, cic_en;
   logic        cic_data_clk;
   logic [15:0] cic_data_out;
   logic [15:0] m_data;
   logic        m_valid, m_ready;
   logic        running, overrun;
`ifdef CIC_CTRL_OVR_CNT_EN
   logic [15:0] ovr_cnt;
`endif

   int          errors = 0;
   int          checks = 0;
   logic [15:0] exp_q[$];
   logic [15:0] sb_exp;
   logic [15:0] stream_vals[5];

   always #5 clk = ~clk;

   cic_ctrl #(
      .DATA_WIDTH_O   (16),
      .RST_CYCLES     (4),
      .SETTLE_OUTPUTS (5)
   ) dut (
      .clk          (clk),
      .arst_n       (arst_n),
      .start        (start),
      .stop         (stop),
      .in_valid     (in_valid),
      .cic_rst_n    (cic_rst_n),
      .cic_en       (cic_en),
      .cic_data_clk (cic_data_clk),
      .cic_data_out (cic_data_out),
      .m_data       (m_data),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .running      (running),
      .overrun      (overrun)
`ifdef CIC_CTRL_OVR_CNT_EN
      ,
      .ovr_cnt      (ovr_cnt)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // CIC model: output register updates the cycle after its strobe.
   task automatic strobe(input logic [15:0] v);
      cic_data_clk = 1'b1;
      tick();
      cic_data_clk = 1'b0;
      cic_data_out = v;
      tick();
   endtask

   task automatic check_reset_window(input string tag);
      for (int i = 0; i < 4; i++) begin
         check(tag, cic_rst_n, 1'b0);
         check({tag, "_en"}, cic_en, 1'b0);
         tick();
      end
      check({tag, "_release"}, cic_rst_n, 1'b1);
   endtask

   always @(negedge clk) begin
      if (arst_n && m_valid && m_ready) begin
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL sb_unexpected observed=0x%0h expected=none", m_data);
         end
         if (exp_q.size() != 0) begin
            sb_exp = exp_q.pop_front();
            checks++;
            assert (m_data === sb_exp) else begin
               errors++;
               $error("FAIL sb_data observed=0x%0h expected=0x%0h", m_data, sb_exp);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      arst_n       = 1'b0;
      start        = 1'b0;
      stop         = 1'b0;
      in_valid     = 1'b1;
      cic_data_clk = 1'b0;
      cic_data_out = '0;
      m_ready      = 1'b0;
      stream_vals  = '{16'h1234, 16'h8001, 16'h7FFF, 16'h0001, 16'hFFFF};

      #3;
      check("rst_cic_rst_n", cic_rst_n, 1'b0);
      check("rst_cic_en", cic_en, 1'b0);
      check("rst_m_valid", m_valid, 1'b0);
      check("rst_m_data", m_data, 16'h0000);
      check("rst_overrun", overrun, 1'b0);
      check("rst_running", running, 1'b0);
      repeat (2) tick();
      arst_n = 1'b1;
      repeat (3) tick();
      check("idle_cic_rst_n", cic_rst_n, 1'b0);
      check("idle_cic_en", cic_en, 1'b0);

      // Start, full reset window, then settle
      start = 1'b1;
      tick();
      start = 1'b0;
      check_reset_window("first_rst_low");
      check("settle_en_follows_valid", cic_en, 1'b1);
      in_valid = 1'b0;
      #1;
      check("settle_en_gated", cic_en, 1'b0);
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         strobe(16'h0BAD);
         check("settle_no_valid", m_valid, 1'b0);
      end
      check("run_entered", running, 1'b1);

      // Sixth output is the first delivered one
      exp_q.push_back(16'h2468);
      cic_data_clk = 1'b1;
      tick();
      cic_data_clk = 1'b0;
      cic_data_out = 16'h2468;
      check("cap_latency", m_valid, 1'b0);
      tick();
      check("first_valid", m_valid, 1'b1);
      check("first_data", m_data, 16'h2468);
      m_ready = 1'b1;
      tick();
      check("first_drained", m_valid, 1'b0);

      // Streaming with m_ready held high
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back(stream_vals[i]);
         strobe(stream_vals[i]);
         repeat (6) tick();
      end
      check("stream_overrun", overrun, 1'b0);
      check("stream_drained", exp_q.size(), 0);

      // Backpressure across three strobes
      m_ready = 1'b0;
      exp_q.push_back(16'hA5A5);
      strobe(16'hA5A5);
      repeat (2) tick();
      strobe(16'h5A5A);
      repeat (2) tick();
      strobe(16'h3C3C);
      repeat (2) tick();
      check("bp_valid", m_valid, 1'b1);
      check("bp_data_held", m_data, 16'hA5A5);
      check("bp_overrun", overrun, 1'b1);
`ifdef CIC_CTRL_OVR_CNT_EN
      check("bp_ovr_cnt", ovr_cnt, 16'd2);
`endif
      m_ready = 1'b1;
      tick();
      check("bp_released", m_valid, 1'b0);
      check("bp_overrun_sticky", overrun, 1'b1);

      // start+stop together from RUN resolves as stop
      start = 1'b1;
      stop  = 1'b1;
      tick();
      start = 1'b0;
      stop  = 1'b0;
      check("ss_running", running, 1'b0);
      check("ss_cic_rst_n", cic_rst_n, 1'b0);
      check("ss_overrun_kept", overrun, 1'b1);

      // Accepted start clears overrun; stop at third settle pulse
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_clr_overrun", overrun, 1'b0);
`ifdef CIC_CTRL_OVR_CNT_EN
      check("start_clr_ovr_cnt", ovr_cnt, 16'd0);
`endif
      check_reset_window("second_rst_low");
      strobe(16'h1111);
      strobe(16'h2222);
      cic_data_clk = 1'b1;
      stop         = 1'b1;
      tick();
      cic_data_clk = 1'b0;
      stop         = 1'b0;
      check("stop_cic_rst_n", cic_rst_n, 1'b0);
      check("stop_cic_en", cic_en, 1'b0);
      check("stop_running", running, 1'b0);
      repeat (3) tick();
      check("stop_stays_idle", cic_rst_n, 1'b0);

      // Restart repeats full reset and settle; start inside SETTLE ignored
      start = 1'b1;
      tick();
      start = 1'b0;
      check_reset_window("third_rst_low");
      strobe(16'h0001);
      strobe(16'h0002);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_in_settle_ignored", cic_rst_n, 1'b1);
      strobe(16'h0003);
      strobe(16'h0004);
      check("settle_4_not_run", running, 1'b0);
      strobe(16'h0005);
      check("settle_5_run", running, 1'b1);
      exp_q.push_back(16'h0F0F);
      strobe(16'h0F0F);
      repeat (2) tick();
      check("restart_drained", exp_q.size(), 0);

      // Asynchronous reset mid-RUN with a held sample
      m_ready = 1'b0;
      strobe(16'h7777);
      check("pre_arst_valid", m_valid, 1'b1);
      #2;
      arst_n = 1'b0;
      #1;
      check("arst_m_valid", m_valid, 1'b0);
      check("arst_m_data", m_data, 16'h0000);
      check("arst_cic_rst_n", cic_rst_n, 1'b0);
      check("arst_cic_en", cic_en, 1'b0);
      check("arst_running", running, 1'b0);
      check("arst_overrun", overrun, 1'b0);
`ifdef CIC_CTRL_OVR_CNT_EN
      check("arst_ovr_cnt", ovr_cnt, 16'd0);
`endif
      tick();
      arst_n = 1'b1;
      repeat (3) tick();
      check("post_arst_idle", cic_rst_n, 1'b0);
      check("post_arst_running", running, 1'b0);
      check("final_sb_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
